// File: rtl/pid_pkg.sv
// Shared types, gain index map and fixed-point helpers for the multi-channel PID.
// Optional feedforward support is selected by PID_FF_EN in the modules that import this package.
package pid_pkg;

  localparam int unsigned ADDR_STRIDE = 8;
  localparam int unsigned FN_W        = 128;

  localparam logic [2:0] GAIN_KP  = 3'd0;
  localparam logic [2:0] GAIN_KI  = 3'd1;
  localparam logic [2:0] GAIN_KD1 = 3'd2;
  localparam logic [2:0] GAIN_KD2 = 3'd3;
  localparam logic [2:0] GAIN_KFF = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_MUL_P,
    S_MUL_I,
    S_MUL_D1,
    S_MUL_D2,
    S_MUL_FF,
    S_CLAMP,
    S_SUM,
    S_OUT
  } pid_state_t;

  // Clamp a wide signed value to the signed range of a w-bit word.
  function automatic logic signed [FN_W-1:0] sat_to_width(
    input logic signed [FN_W-1:0] x,
    input int unsigned            w
  );
    logic signed [FN_W-1:0] hi;
    logic signed [FN_W-1:0] lo;
    hi = (FN_W'(1) <<< (w - 1)) - FN_W'(1);
    lo = -hi - FN_W'(1);
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

  // Full-precision multiply, arithmetic shift by the gain fraction, saturate to w bits.
  function automatic logic signed [FN_W-1:0] mul_q(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        q,
    input int unsigned        w
  );
    logic signed [FN_W-1:0] prod;
    prod = FN_W'(a) * FN_W'(b);
    return sat_to_width(prod >>> q, w);
  endfunction

endpackage

// File: rtl/pid_mc_regs.sv
// Per-channel gain register file: address decode on writes, combinational read by channel.
// PID_FF_EN adds the feedforward gain (index 4) and its read port.
module pid_mc_regs
  import pid_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int N_CH    = 4,
  parameter int CH_W    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic        [D_WIDTH-1:0] cfg_addr,
  input  logic signed [D_WIDTH-1:0] cfg_data,
  input  logic        [CH_W-1:0]    rd_ch,
  output logic signed [D_WIDTH-1:0] kp_c,
  output logic signed [D_WIDTH-1:0] ki_c,
  output logic signed [D_WIDTH-1:0] kd1_c,
  output logic signed [D_WIDTH-1:0] kd2_c
`ifdef PID_FF_EN
  ,output logic signed [D_WIDTH-1:0] kff_c
`endif
);

  localparam int unsigned K_W = $clog2(ADDR_STRIDE);
  localparam int unsigned A_W = D_WIDTH - K_W;

  logic [A_W-1:0] wr_ch;
  logic [K_W-1:0] wr_k;
  logic           wr_ok;

  logic signed [D_WIDTH-1:0] kp_q  [N_CH];
  logic signed [D_WIDTH-1:0] ki_q  [N_CH];
  logic signed [D_WIDTH-1:0] kd1_q [N_CH];
  logic signed [D_WIDTH-1:0] kd2_q [N_CH];
`ifdef PID_FF_EN
  logic signed [D_WIDTH-1:0] kff_q [N_CH];
`endif

  assign wr_ch = cfg_addr[D_WIDTH-1:K_W];
  assign wr_k  = cfg_addr[K_W-1:0];
  assign wr_ok = cfg_we && (wr_ch < A_W'(N_CH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        kp_q[i]  <= '0;
        ki_q[i]  <= '0;
        kd1_q[i] <= '0;
        kd2_q[i] <= '0;
`ifdef PID_FF_EN
        kff_q[i] <= '0;
`endif
      end
    end else if (wr_ok) begin
      case (wr_k)
        GAIN_KP:  kp_q[CH_W'(wr_ch)]  <= cfg_data;
        GAIN_KI:  ki_q[CH_W'(wr_ch)]  <= cfg_data;
        GAIN_KD1: kd1_q[CH_W'(wr_ch)] <= cfg_data;
        GAIN_KD2: kd2_q[CH_W'(wr_ch)] <= cfg_data;
`ifdef PID_FF_EN
        GAIN_KFF: kff_q[CH_W'(wr_ch)] <= cfg_data;
`endif
        default: ;
      endcase
    end
  end

  // Out-of-range channels read as all-zero gains.
  always_comb begin
    kp_c  = '0;
    ki_c  = '0;
    kd1_c = '0;
    kd2_c = '0;
`ifdef PID_FF_EN
    kff_c = '0;
`endif
    if (int'(rd_ch) < N_CH) begin
      kp_c  = kp_q[rd_ch];
      ki_c  = ki_q[rd_ch];
      kd1_c = kd1_q[rd_ch];
      kd2_c = kd2_q[rd_ch];
`ifdef PID_FF_EN
      kff_c = kff_q[rd_ch];
`endif
    end
  end

endmodule

// File: rtl/pid_mc.sv
// Time-multiplexed multi-channel PID with one shared multiplier and anti-windup clamp.
// Define PID_FF_EN to add a per-channel feedforward term (kff*target) and its MUL_FF step.
module pid_mc
  import pid_pkg::*;
#(
  parameter  int D_WIDTH = 32,
  parameter  int Q_BITS  = 15,
  parameter  int N_CH    = 4,
  parameter  int LIM_MAX = 4096,
  parameter  int LIM_MIN = -4096,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic        [D_WIDTH-1:0] cfg_addr,
  input  logic signed [D_WIDTH-1:0] cfg_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic        [CH_W-1:0]    in_ch,
  input  logic signed [D_WIDTH-1:0] target,
  input  logic signed [D_WIDTH-1:0] measurement,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic        [CH_W-1:0]    out_ch,
  output logic signed [D_WIDTH-1:0] out_data,
  output logic                      out_sat
);

  localparam int unsigned E_W = D_WIDTH + 1;
  localparam int unsigned S_W = D_WIDTH + 3;

  typedef logic signed [D_WIDTH-1:0] data_t;
  typedef logic signed [S_W-1:0]     wide_t;

  localparam wide_t LIM_MAX_S = S_W'(LIM_MAX);
  localparam wide_t LIM_MIN_S = S_W'(LIM_MIN);
  localparam wide_t ZERO_S    = '0;

  pid_state_t        state_q;
  logic [CH_W-1:0]   ch_q;
  data_t             tgt_q, meas_q, e_q;
  data_t             kp_s, ki_s, kd1_s, kd2_s;
  data_t             i_s, pe_s, pd_s;
  data_t             p_q, ic_q, d1_q, d_q;
  data_t             integ_q [N_CH];
  data_t             perr_q  [N_CH];
  data_t             pder_q  [N_CH];
  logic              out_valid_q, out_sat_q;
  logic [CH_W-1:0]   out_ch_q;
  data_t             out_data_q;
  data_t             kp_c, ki_c, kd1_c, kd2_c;
`ifdef PID_FF_EN
  data_t             kff_c, kff_s, ff_q;
`endif

  logic signed [E_W-1:0] err_w, e_sum, e_dif, mul_b;
  data_t                 err_c, mul_a, mul_r, ic_sum, d_sum, ic_cl;
  wide_t                 pf, hi, lo, u, u_cl;
  logic                  u_sat, ch_ok;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  pid_mc_regs #(
    .D_WIDTH (D_WIDTH),
    .N_CH    (N_CH),
    .CH_W    (CH_W)
  ) u_regs (
    .clock    (clock),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .rd_ch    (ch_q),
    .kp_c     (kp_c),
    .ki_c     (ki_c),
    .kd1_c    (kd1_c),
    .kd2_c    (kd2_c)
`ifdef PID_FF_EN
    ,.kff_c   (kff_c)
`endif
  );

  // Datapath: shared multiplier operand select, saturating sums, anti-windup and output clamp.
  always_comb begin
    ch_ok = int'(ch_q) < N_CH;
    err_w = E_W'(tgt_q) - E_W'(meas_q);
    err_c = D_WIDTH'(sat_to_width(FN_W'(err_w), D_WIDTH));
    e_sum = E_W'(e_q) + E_W'(pe_s);
    e_dif = E_W'(e_q) - E_W'(pe_s);

    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MUL_P:  begin mul_a = kp_s;  mul_b = E_W'(e_q);  end
      S_MUL_I:  begin mul_a = ki_s;  mul_b = e_sum;      end
      S_MUL_D1: begin mul_a = kd1_s; mul_b = e_dif;      end
      S_MUL_D2: begin mul_a = kd2_s; mul_b = E_W'(pd_s); end
`ifdef PID_FF_EN
      S_MUL_FF: begin mul_a = kff_s; mul_b = E_W'(tgt_q); end
`endif
      default: ;
    endcase
    mul_r = D_WIDTH'(mul_q(64'(mul_a), 64'(mul_b), Q_BITS, D_WIDTH));

    ic_sum = D_WIDTH'(sat_to_width(FN_W'(S_W'(i_s) + S_W'(mul_r)), D_WIDTH));
    d_sum  = D_WIDTH'(sat_to_width(FN_W'(S_W'(d1_q) + S_W'(mul_r)), D_WIDTH));

    pf = S_W'(p_q);
`ifdef PID_FF_EN
    pf = pf + S_W'(ff_q);
`endif
    hi = LIM_MAX_S - pf;
    if (hi < ZERO_S) hi = ZERO_S;
    lo = LIM_MIN_S - pf;
    if (lo > ZERO_S) lo = ZERO_S;
    ic_cl = ic_q;
    if (S_W'(ic_q) > hi) ic_cl = D_WIDTH'(hi);
    else if (S_W'(ic_q) < lo) ic_cl = D_WIDTH'(lo);

    u = pf + S_W'(ic_q) + S_W'(d_q);
    u_cl  = u;
    u_sat = 1'b0;
    if (u > LIM_MAX_S) begin
      u_cl  = LIM_MAX_S;
      u_sat = 1'b1;
    end else if (u < LIM_MIN_S) begin
      u_cl  = LIM_MIN_S;
      u_sat = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      tgt_q       <= '0;
      meas_q      <= '0;
      e_q         <= '0;
      kp_s        <= '0;
      ki_s        <= '0;
      kd1_s       <= '0;
      kd2_s       <= '0;
      i_s         <= '0;
      pe_s        <= '0;
      pd_s        <= '0;
      p_q         <= '0;
      ic_q        <= '0;
      d1_q        <= '0;
      d_q         <= '0;
`ifdef PID_FF_EN
      kff_s       <= '0;
      ff_q        <= '0;
`endif
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        integ_q[i] <= '0;
        perr_q[i]  <= '0;
        pder_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          ch_q    <= in_ch;
          tgt_q   <= target;
          meas_q  <= measurement;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          e_q   <= err_c;
          kp_s  <= kp_c;
          ki_s  <= ki_c;
          kd1_s <= kd1_c;
          kd2_s <= kd2_c;
`ifdef PID_FF_EN
          kff_s <= kff_c;
`endif
          i_s   <= ch_ok ? integ_q[ch_q] : '0;
          pe_s  <= ch_ok ? perr_q[ch_q]  : '0;
          pd_s  <= ch_ok ? pder_q[ch_q]  : '0;
          state_q <= S_MUL_P;
        end
        S_MUL_P: begin
          p_q     <= mul_r;
          state_q <= S_MUL_I;
        end
        S_MUL_I: begin
          ic_q    <= ic_sum;
          state_q <= S_MUL_D1;
        end
        S_MUL_D1: begin
          d1_q    <= mul_r;
          state_q <= S_MUL_D2;
        end
        S_MUL_D2: begin
          d_q <= d_sum;
`ifdef PID_FF_EN
          state_q <= S_MUL_FF;
`else
          state_q <= S_CLAMP;
`endif
        end
`ifdef PID_FF_EN
        S_MUL_FF: begin
          ff_q    <= mul_r;
          state_q <= S_CLAMP;
        end
`endif
        S_CLAMP: begin
          ic_q    <= ic_cl;
          state_q <= S_SUM;
        end
        // History is committed here so output backpressure cannot disturb it.
        S_SUM: begin
          out_data_q  <= D_WIDTH'(u_cl);
          out_sat_q   <= u_sat;
          out_ch_q    <= ch_q;
          out_valid_q <= 1'b1;
          if (ch_ok) begin
            integ_q[ch_q] <= ic_q;
            perr_q[ch_q]  <= e_q;
            pder_q[ch_q]  <= d_q;
          end
          state_q <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_mc.sv
// Directed bench for pid_mc: proportional, saturation, integrator/anti-windup,
// derivative, interleaving with backpressure, and mid-operation reset.
module tb_pid_mc;

`ifdef PID_FF_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               cfg_we = 1'b0;
  logic        [31:0] cfg_addr = '0;
  logic signed [31:0] cfg_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic        [1:0]  in_ch = '0;
  logic signed [31:0] target = '0;
  logic signed [31:0] measurement = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic        [1:0]  out_ch;
  logic signed [31:0] out_data;
  logic               out_sat;

  int errors = 0;
  int checks = 0;

  pid_mc dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ch       (in_ch),
    .target      (target),
    .measurement (measurement),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_data    (out_data),
    .out_sat     (out_sat)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic cfg_write(input int addr, input int data);
    @(negedge clock);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    @(negedge clock);
    cfg_we   = 1'b0;
  endtask

  // Present a sample and return just after the accept edge.
  task automatic start(input int ch, input int tgt, input int meas);
    int n;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL start_timeout in_ready=%0b required=1", in_ready);
    end
    in_valid    = 1'b1;
    in_ch       = 2'(ch);
    target      = tgt;
    measurement = meas;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  // Cycles counted from the accept cycle (accept cycle = 1) until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    @(negedge clock);
    while (!out_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_timeout out_valid=%0b required=1", out_valid);
    end
  endtask

  task automatic send(input int ch, input int tgt, input int meas,
                      output int d, output int c, output logic s, output int lat);
    start(ch, tgt, meas);
    wait_out(lat);
    d = out_data;
    c = int'(out_ch);
    s = out_sat;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b required=0", out_valid); end
    checks++; if (out_data !== 32'sd0) begin errors++; $display("FAIL rst_data got=%0d required=0", out_data); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL rst_ch got=%0d required=0", out_ch); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL rst_sat got=%0b required=0", out_sat); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0b required=1", in_ready); end
  endtask

  task automatic test_proportional();
    int d, c, lat; logic s;
    cfg_write(0, 32768);
    send(0, 1000, 0, d, c, s, lat);
    checks++; if (d !== 1000) begin errors++; $display("FAIL prop_data got=%0d required=1000", d); end
    checks++; if (c !== 0) begin errors++; $display("FAIL prop_ch got=%0d required=0", c); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL prop_sat got=%0b required=0", s); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL prop_latency got=%0d required=%0d", lat, LAT); end
  endtask

  task automatic test_saturation();
    int d, c, lat; logic s;
    send(0, 10000, 0, d, c, s, lat);
    checks++; if (d !== 4096) begin errors++; $display("FAIL sat_hi_data got=%0d required=4096", d); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL sat_hi_flag got=%0b required=1", s); end
    send(0, -10000, 0, d, c, s, lat);
    checks++; if (d !== -4096) begin errors++; $display("FAIL sat_lo_data got=%0d required=-4096", d); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL sat_lo_flag got=%0b required=1", s); end
  endtask

  task automatic test_integrator();
    int d, c, lat; logic s;
    int exp_i [3] = '{50, 150, 250};
    cfg_write(9, 16384);
    for (int k = 0; k < 3; k++) begin
      send(1, 100, 0, d, c, s, lat);
      checks++; if (d !== exp_i[k]) begin errors++; $display("FAIL integ_%0d got=%0d required=%0d", k, d, exp_i[k]); end
    end
    checks++; if (c !== 1) begin errors++; $display("FAIL integ_ch got=%0d required=1", c); end
    cfg_write(8, 32768);
    send(1, 5000, 0, d, c, s, lat);
    checks++; if (d !== 4096) begin errors++; $display("FAIL windup_data got=%0d required=4096", d); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL windup_sat got=%0b required=1", s); end
  endtask

  task automatic test_derivative();
    int d, c, lat; logic s;
    cfg_write(18, 32768);
    send(2, 100, 0, d, c, s, lat);
    checks++; if (d !== 100) begin errors++; $display("FAIL deriv_a0 got=%0d required=100", d); end
    send(2, 100, 0, d, c, s, lat);
    checks++; if (d !== 0) begin errors++; $display("FAIL deriv_a1 got=%0d required=0", d); end
    cfg_write(26, 32768);
    cfg_write(27, 16384);
    send(3, 100, 0, d, c, s, lat);
    checks++; if (d !== 100) begin errors++; $display("FAIL deriv_b0 got=%0d required=100", d); end
    send(3, 100, 0, d, c, s, lat);
    checks++; if (d !== 50) begin errors++; $display("FAIL deriv_b1 got=%0d required=50", d); end
    checks++; if (c !== 3) begin errors++; $display("FAIL deriv_ch got=%0d required=3", c); end
  endtask

  task automatic test_back_to_back();
    int d, c, lat; logic s;
    out_ready = 1'b0;
    start(0, 200, 0);
    @(posedge clock);
    cfg_write(0, 16384);
    wait_out(lat);
    for (int k = 0; k < 20; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d got=%0b required=1", k, out_valid); end
      checks++; if (out_data !== 32'sd200) begin errors++; $display("FAIL bp_data_%0d got=%0d required=200", k, out_data); end
      checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL bp_ch_%0d got=%0d required=0", k, out_ch); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d got=%0b required=0", k, in_ready); end
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%0b required=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b required=1", in_ready); end
    send(3, 100, 0, d, c, s, lat);
    checks++; if (d !== 25) begin errors++; $display("FAIL iso_ch3_a got=%0d required=25", d); end
    send(0, 200, 0, d, c, s, lat);
    checks++; if (d !== 100) begin errors++; $display("FAIL iso_ch0_newgain got=%0d required=100", d); end
    send(3, 100, 0, d, c, s, lat);
    checks++; if (d !== 12) begin errors++; $display("FAIL iso_ch3_b got=%0d required=12", d); end
  endtask

  task automatic test_reset_midop();
    int d, c, lat; logic s;
    start(1, 5000, 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b required=0", out_valid); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%0b required=1", in_ready); end
    send(1, 5000, 0, d, c, s, lat);
    checks++; if (d !== 0) begin errors++; $display("FAIL midrst_ch1 got=%0d required=0", d); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL midrst_sat got=%0b required=0", s); end
    send(0, 1000, 0, d, c, s, lat);
    checks++; if (d !== 0) begin errors++; $display("FAIL midrst_ch0 got=%0d required=0", d); end
    send(3, 100, 0, d, c, s, lat);
    checks++; if (d !== 0) begin errors++; $display("FAIL midrst_ch3 got=%0d required=0", d); end
  endtask

  initial begin
    test_reset();
    test_proportional();
    test_saturation();
    test_integrator();
    test_derivative();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
